// File: rtl/bsr_chain_pkg.sv
// Shared constants for the boundary-scan register: test modes and cell
// ordering within one pad's three-bit group of the chain.
package jtag_bsr_pkg;

   localparam logic [1:0] MODE_FUNC   = 2'b00;
   localparam logic [1:0] MODE_EXTEST = 2'b01;
   localparam logic [1:0] MODE_INTEST = 2'b10;

   localparam int CELL_IN       = 0;
   localparam int CELL_OUT      = 1;
   localparam int CELL_CTL      = 2;
   localparam int CELLS_PER_PIN = 3;

   // Both test modes drive the pads from the update stage.
   function automatic logic pads_from_ur(input logic [1:0] mode);
      return (mode == MODE_EXTEST) || (mode == MODE_INTEST);
   endfunction

endpackage

// File: rtl/bsr_chain_if.sv
// TAP-side view of the boundary-scan register: DR strobes, select and the
// serial data pair.
interface bsr_chain_if;
   logic select;
   logic capture_dr;
   logic shift_dr;
   logic update_dr;
   logic tdi;
   logic tdo;

   modport master (output select, capture_dr, shift_dr, update_dr, tdi, input tdo);
   modport slave  (input select, capture_dr, shift_dr, update_dr, tdi, output tdo);
endinterface

// File: rtl/bsr_pin_slice.sv
// One pad's worth of boundary scan: input, output and control cells with
// their update latches, plus the pad/core steering for that pad.
module bsr_pin_slice
   import jtag_bsr_pkg::*;
#(
   parameter logic OE_RESET = 1'b0
) (
   input  logic       tck,
   input  logic       resetn,
   input  logic       select,
   input  logic       capture_dr,
   input  logic       shift_dr,
   input  logic       update_dr,
   input  logic [1:0] mode,
   input  logic       enable_in,
   input  logic       enable_out,
   input  logic       si,
   output logic       so,
   input  logic       core_out,
   input  logic       core_oe,
   output logic       core_in,
   input  logic       pad_in,
   output logic       pad_out,
   output logic       pad_oe
);

   localparam logic [CELLS_PER_PIN-1:0] UR_RST = CELLS_PER_PIN'(OE_RESET) << CELL_CTL;

   logic [CELLS_PER_PIN-1:0] sr_q, sr_d;
   logic [CELLS_PER_PIN-1:0] ur_q, ur_d;

   // Capture outranks shift; a blocked capture still suppresses the shift.
   always_comb begin
      sr_d = sr_q;
      if (select) begin
         if (capture_dr) begin
            if (enable_in) begin
               sr_d[CELL_IN]  = pad_in;
               sr_d[CELL_OUT] = core_out;
               sr_d[CELL_CTL] = core_oe;
            end
         end else if (shift_dr) begin
            sr_d = {si, sr_q[CELLS_PER_PIN-1:1]};
         end
      end
   end

   always_ff @(posedge tck or negedge resetn) begin
      if (!resetn) sr_q <= '0;
      else         sr_q <= sr_d;
   end

   assign ur_d = (select && update_dr) ? sr_q : ur_q;

   // Update stage loads on the falling edge so pads change mid Update-DR.
   always_ff @(negedge tck or negedge resetn) begin
      if (!resetn) ur_q <= UR_RST;
      else         ur_q <= ur_d;
   end

   assign so = sr_q[CELL_IN];

   always_comb begin
      pad_out = core_out;
      pad_oe  = core_oe;
      core_in = (mode == MODE_INTEST) ? ur_q[CELL_IN] : pad_in;
      if (!enable_out) begin
         pad_out = 1'b0;
         pad_oe  = 1'b0;
      end else if (pads_from_ur(mode)) begin
         pad_out = ur_q[CELL_OUT];
         pad_oe  = ur_q[CELL_CTL];
      end
   end

endmodule

// File: rtl/bsr_chain.sv
// Boundary-scan register for NUM_PINS bidirectional pads; pad i owns chain
// bits 3i..3i+2, tdi enters the top bit and tdo is bit 0.
module bsr_chain
   import jtag_bsr_pkg::*;
#(
   parameter int   NUM_PINS = 8,
   parameter logic OE_RESET = 1'b0
) (
   input  logic                tck,
   input  logic                resetn,
   bsr_chain_if.slave          tap,
   input  logic [1:0]          mode,
   input  logic                enable_in,
   input  logic                enable_out,
   input  logic [NUM_PINS-1:0] core_out,
   input  logic [NUM_PINS-1:0] core_oe,
   output logic [NUM_PINS-1:0] core_in,
   input  logic [NUM_PINS-1:0] pad_in,
   output logic [NUM_PINS-1:0] pad_out,
   output logic [NUM_PINS-1:0] pad_oe
);

   // chain[i+1] feeds slice i; chain[0] is the serial output.
   logic [NUM_PINS:0] chain;

   assign chain[NUM_PINS] = tap.tdi;

   generate
      for (genvar gi = 0; gi < NUM_PINS; gi++) begin : g_pin
         bsr_pin_slice #(
            .OE_RESET (OE_RESET)
         ) u_slice (
            .tck        (tck),
            .resetn     (resetn),
            .select     (tap.select),
            .capture_dr (tap.capture_dr),
            .shift_dr   (tap.shift_dr),
            .update_dr  (tap.update_dr),
            .mode       (mode),
            .enable_in  (enable_in),
            .enable_out (enable_out),
            .si         (chain[gi+1]),
            .so         (chain[gi]),
            .core_out   (core_out[gi]),
            .core_oe    (core_oe[gi]),
            .core_in    (core_in[gi]),
            .pad_in     (pad_in[gi]),
            .pad_out    (pad_out[gi]),
            .pad_oe     (pad_oe[gi])
         );
      end
   endgenerate

   assign tap.tdo = resetn & chain[0];

endmodule

// File: tb/tb_bsr_chain.sv
// Scoreboarded bench for bsr_chain: a queue-based chain model predicts
// tdo and pad/core outputs, a monitor pops and compares each prediction.
module tb_bsr_chain;
   import jtag_bsr_pkg::*;

   localparam int   NP   = 8;
   localparam int   LEN  = 3 * NP;
   localparam logic OE_R = 1'b0;

   localparam int K_TDO = 0, K_POUT = 1, K_POE = 2, K_CIN = 3;

   logic          tck = 1'b0;
   logic          resetn;
   logic [1:0]    mode;
   logic          enable_in, enable_out;
   logic [NP-1:0] core_out, core_oe, core_in, pad_in, pad_out, pad_oe;

   bsr_chain_if tap ();

   bsr_chain #(.NUM_PINS(NP), .OE_RESET(OE_R)) dut (
      .tck        (tck),
      .resetn     (resetn),
      .tap        (tap.slave),
      .mode       (mode),
      .enable_in  (enable_in),
      .enable_out (enable_out),
      .core_out   (core_out),
      .core_oe    (core_oe),
      .core_in    (core_in),
      .pad_in     (pad_in),
      .pad_out    (pad_out),
      .pad_oe     (pad_oe)
   );

   always #5 tck = ~tck;

   typedef struct {
      string         name;
      int            kind;
      logic [NP-1:0] exp;
   } exp_t;

   exp_t exp_q[$];
   event chk_ev;
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference: the chain as a queue (front = tdo end), update stage as an array.
   bit m_sr[$];
   bit m_ur[LEN];

   function automatic void model_reset();
      m_sr.delete();
      for (int k = 0; k < LEN; k++) m_sr.push_back(1'b0);
      for (int i = 0; i < NP; i++) begin
         m_ur[3*i]   = 1'b0;
         m_ur[3*i+1] = 1'b0;
         m_ur[3*i+2] = OE_R;
      end
   endfunction

   function automatic void model_clock(bit sel, bit cap, bit sh, bit upd, bit din);
      if (!sel) return;
      if (cap) begin
         if (enable_in)
            for (int i = 0; i < NP; i++) begin
               m_sr[3*i]   = pad_in[i];
               m_sr[3*i+1] = core_out[i];
               m_sr[3*i+2] = core_oe[i];
            end
      end else if (sh) begin
         void'(m_sr.pop_front());
         m_sr.push_back(din);
      end
      if (upd)
         for (int k = 0; k < LEN; k++) m_ur[k] = m_sr[k];
   endfunction

   task automatic fire(string tag);
      ->chk_ev;
      #1;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s_monitor: %0d predictions left unchecked, required 0", tag, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic push(string name, int kind, logic [NP-1:0] e);
      exp_t it;
      it.name = name;
      it.kind = kind;
      it.exp  = e;
      exp_q.push_back(it);
   endtask

   task automatic check_val(string name, int kind, logic [NP-1:0] e);
      push(name, kind, e);
      fire(name);
   endtask

   task automatic expect_outputs(string tag);
      logic [NP-1:0] e_po, e_oe, e_ci;
      logic [NP-1:0] e_tdo;
      e_tdo = '0;
      e_tdo[0] = resetn ? m_sr[0] : 1'b0;
      for (int i = 0; i < NP; i++) begin
         if (!enable_out) begin
            e_po[i] = 1'b0;
            e_oe[i] = 1'b0;
         end else if (mode == MODE_EXTEST || mode == MODE_INTEST) begin
            e_po[i] = m_ur[3*i+1];
            e_oe[i] = m_ur[3*i+2];
         end else begin
            e_po[i] = core_out[i];
            e_oe[i] = core_oe[i];
         end
         e_ci[i] = (mode == MODE_INTEST) ? m_ur[3*i] : pad_in[i];
      end
      push({tag, "_tdo"}, K_TDO, e_tdo);
      push({tag, "_pad_out"}, K_POUT, e_po);
      push({tag, "_pad_oe"}, K_POE, e_oe);
      push({tag, "_core_in"}, K_CIN, e_ci);
      fire(tag);
   endtask

   // One tck cycle, entered and left just after a falling edge.
   task automatic cycle(bit sel, bit cap, bit sh, bit upd, bit din, string tag, bit mid = 1'b0);
      tap.select     = sel;
      tap.capture_dr = cap;
      tap.shift_dr   = sh;
      tap.update_dr  = upd;
      tap.tdi        = din;
      #1;
      expect_outputs(tag);
      if (mid) begin
         @(posedge tck);
         #1;
         expect_outputs({tag, "_pre_negedge"});
      end
      @(negedge tck);
      #1;
      model_clock(sel, cap, sh, upd, din);
   endtask

   task automatic shift_out(string tag);
      for (int k = 0; k < LEN; k++) cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'($urandom), tag);
   endtask

   task automatic load_and_update(logic [NP-1:0] in_v, logic [NP-1:0] out_v, logic [NP-1:0] ctl_v, string tag);
      bit t[LEN];
      for (int i = 0; i < NP; i++) begin
         t[3*i]   = in_v[i];
         t[3*i+1] = out_v[i];
         t[3*i+2] = ctl_v[i];
      end
      for (int k = 0; k < LEN; k++) cycle(1'b1, 1'b0, 1'b1, 1'b0, t[k], {tag, "_shift"});
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, {tag, "_update"}, 1'b1);
      tap.update_dr = 1'b0;
   endtask

   initial begin : monitor
      forever begin
         @chk_ev;
         while (exp_q.size() > 0) begin
            exp_t          e;
            logic [NP-1:0] act;
            e = exp_q.pop_front();
            case (e.kind)
               K_TDO:   act = {{(NP-1){1'b0}}, tap.tdo};
               K_POUT:  act = pad_out;
               K_POE:   act = pad_oe;
               default: act = core_in;
            endcase
            n_checks++;
            if (act !== e.exp) begin
               n_fail++;
               $display("FAIL %s: got %h required %h", e.name, act, e.exp);
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : driver
      resetn         = 1'b0;
      mode           = MODE_FUNC;
      enable_in      = 1'b1;
      enable_out     = 1'b1;
      core_out       = '0;
      core_oe        = '0;
      pad_in         = '0;
      tap.select     = 1'b0;
      tap.capture_dr = 1'b0;
      tap.shift_dr   = 1'b0;
      tap.update_dr  = 1'b0;
      tap.tdi        = 1'b0;
      model_reset();
      @(negedge tck);
      #1;
      expect_outputs("por");
      resetn = 1'b1;

      // Async reset in the middle of a shift, after non-trivial update state.
      mode = MODE_EXTEST;
      load_and_update(8'h33, 8'hFF, 8'hF0, "pre_rst");
      for (int k = 0; k < 7; k++) cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "pre_rst_shift");
      tap.shift_dr = 1'b1;
      tap.tdi      = 1'b1;
      #2;
      resetn = 1'b0;
      model_reset();
      #1;
      expect_outputs("rst_async");
      check_val("rst_pad_oe", K_POE, 8'h00);
      check_val("rst_pad_out", K_POUT, 8'h00);
      @(negedge tck);
      #1;
      expect_outputs("rst_hold");
      resetn = 1'b1;
      for (int k = 0; k < LEN; k++) cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "rst_zero");

      // Capture then shift out.
      mode     = MODE_FUNC;
      pad_in   = 8'hA5;
      core_out = 8'h3C;
      core_oe  = 8'hFF;
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "capture");
      shift_out("cap_shift");

      // Extest.
      load_and_update(8'h00, 8'h96, 8'h0F, "extest");
      mode = MODE_EXTEST;
      #1;
      expect_outputs("extest");
      check_val("extest_pad_out", K_POUT, 8'h96);
      check_val("extest_pad_oe", K_POE, 8'h0F);
      enable_out = 1'b0;
      #1;
      check_val("extest_disabled_oe", K_POE, 8'h00);
      expect_outputs("extest_disabled");
      enable_out = 1'b1;

      // Intest, then functional bypass.
      load_and_update(8'h5A, 8'hC3, 8'hAA, "intest");
      mode   = MODE_INTEST;
      pad_in = 8'h00;
      #1;
      check_val("intest_core_in", K_CIN, 8'h5A);
      expect_outputs("intest");
      mode = MODE_FUNC;
      #1;
      check_val("func_core_in", K_CIN, 8'h00);
      check_val("func_pad_out", K_POUT, core_out);
      expect_outputs("func");

      // Blocked capture holds the previously shifted contents.
      enable_in = 1'b0;
      pad_in    = 8'hFF;
      core_out  = 8'h00;
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "cap_blocked");
      enable_in = 1'b1;
      shift_out("cap_blocked_shift");

      // Deselected strobes do nothing.
      mode = MODE_EXTEST;
      for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'($urandom), "deselected");
      cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, "deselected_cap");
      shift_out("deselected_shift");

      // Capture beats shift in the same cycle.
      pad_in   = 8'h69;
      core_out = 8'hE1;
      core_oe  = 8'h1E;
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, "cap_and_shift");
      shift_out("cap_and_shift_out");

      // Random traffic.
      for (int n = 0; n < 300; n++) begin
         mode       = 2'($urandom);
         enable_in  = ($urandom_range(0, 3) != 0);
         enable_out = ($urandom_range(0, 3) != 0);
         core_out   = NP'($urandom);
         core_oe    = NP'($urandom);
         pad_in     = NP'($urandom);
         cycle(($urandom_range(0, 7) != 0), ($urandom_range(0, 5) == 0), 1'($urandom),
               ($urandom_range(0, 4) == 0), 1'($urandom), "random");
      end
      expect_outputs("final");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bsr_chain.md
Name: bsr_chain

Overview:
- Parametrised boundary-scan register covering NUM_PINS bidirectional pads.
- Each pad gets three cells:
  - an input capture cell;
  - an output data cell;
  - an output-enable control cell.
- Sits between the JTAG TAP controller and the pad ring. The TAP drives the capture/shift/update strobes and selects this register as the active DR.
- Unlike the single BC_1 cell, it has a single tck domain with strobe enables (no gated clkDR/updateDR), an intest mode, and per-pad output-enable control.

Parameters:
- NUM_PINS, 8, number of bidirectional pads covered; chain length LEN = 3*NUM_PINS.
- OE_RESET, 1'b0, reset value of every update-stage control cell (0 = pad tristated).

Ports:
- tck  input  1  JTAG test clock.
- resetn  input  1  asynchronous, active-low reset (TAP TRST or Test-Logic-Reset).
- select  input  1  this register is the active DR; all strobes are ignored when 0.
- capture_dr  input  1  TAP in Capture-DR.
- shift_dr  input  1  TAP in Shift-DR.
- update_dr  input  1  TAP in Update-DR.
- mode  input  2  00 functional, 01 extest, 10 intest, 11 treated as functional.
- enable_in  input  1  capture enable; 0 blocks capture_dr.
- enable_out  input  1  pad drive enable; 0 forces pad_out=0 and pad_oe=0.
- tdi  input  1  serial in.
- tdo  output  1  serial out.
- core_out  input  NUM_PINS  core data toward the pads.
- core_oe  input  NUM_PINS  core output enables.
- core_in  output  NUM_PINS  pad data toward the core.
- pad_in  input  NUM_PINS  pad input buffers.
- pad_out  output  NUM_PINS  pad output data.
- pad_oe  output  NUM_PINS  pad output enables.

Behaviour:
- Chain bit mapping for pad i:
  - bit 3i: input cell;
  - bit 3i+1: output cell;
  - bit 3i+2: control cell.
- tdi enters bit LEN-1; tdo = sr[0], combinational. tdo is forced 0 while resetn=0. The falling-edge tdo retiming belongs to the TAP.
- Shift stage sr[LEN-1:0] updates on posedge tck, priority order:
  1. select=0: hold.
  2. capture_dr=1 and enable_in=1: sr[3i]<=pad_in[i], sr[3i+1]<=core_out[i], sr[3i+2]<=core_oe[i].
  3. capture_dr=1 and enable_in=0: hold.
  4. shift_dr=1: sr <= {tdi, sr[LEN-1:1]}.
  5. Otherwise: hold.
- capture_dr and shift_dr asserted together: capture wins.
- Update stage ur[LEN-1:0] loads on negedge tck: ur <= sr when select=1 and update_dr=1; otherwise it holds.
- Reset (asynchronous, any time including mid-shift):
  - sr = 0;
  - ur = 0 except control cells ur[3i+2] = OE_RESET.
  - Outputs follow combinationally from the reset state and the current mode.
- Pad output logic, combinational, per pad i:
  - enable_out=0: pad_out=0, pad_oe=0.
  - mode 01 or 10: pad_out=ur[3i+1], pad_oe=ur[3i+2].
  - otherwise: pad_out=core_out[i], pad_oe=core_oe[i].
- Core input logic, combinational, per pad i:
  - mode 10: core_in[i]=ur[3i].
  - otherwise: core_in[i]=pad_in[i].
- Latency:
  - a shifted bit reaches tdo after its chain position + 1 shift clocks;
  - ur becomes visible on pads half a tck cycle after the posedge ending Shift-DR/Exit-DR (i.e. at the Update-DR falling edge).
- Mode changes take effect immediately on outputs; sr and ur are unaffected.

Decomposition:
- Package jtag_bsr_pkg:
  - mode constants MODE_FUNC=2'b00, MODE_EXTEST=2'b01, MODE_INTEST=2'b10;
  - cell offsets CELL_IN=0, CELL_OUT=1, CELL_CTL=2;
  - CELLS_PER_PIN=3.
- One sub-module, bsr_pin_slice: the three shift/update cells plus the per-pad muxing for one pad. It has a serial in/out and a 3-bit slice of sr/ur. bsr_chain instantiates it NUM_PINS times with a generate loop and ties tdi/tdo at the ends.

Test Plan:
- Reset: resetn=0 mid-shift with OE_RESET=0, mode=01, enable_out=1 -> tdo=0, pad_oe=0, pad_out=0; after release, shift 24 bits of 0 -> tdo stays 0.
- Capture then shift, NUM_PINS=8:
  - setup: pad_in=8'hA5, core_out=8'h3C, core_oe=8'hFF, capture_dr=1 then 24 shifts;
  - required: tdo sequence per pad i is pad_in[i], core_out[i], 1, for i=0..7.
- Extest: shift in a pattern setting ur out cells = 8'h96 and ctl cells = 8'h0F, pulse update_dr, mode=01 -> pad_out=8'h96, pad_oe=8'h0F; pads stay unchanged before the update negedge.
- Intest and functional bypass:
  - mode=10 with ur in-cells = 8'h5A, pad_in=8'h00 -> core_in=8'h5A;
  - switch to mode=00 -> core_in=8'h00, pad_out=core_out.
- Gating:
  - enable_in=0 with capture_dr=1 -> sr holds its previously shifted value;
  - select=0 with shift_dr/update_dr pulses -> sr and ur unchanged;
  - enable_out=0 in extest -> pad_oe=0.
- Priority: capture_dr=1 and shift_dr=1 in the same cycle -> capture result loaded, no shift.
